// File: rtl/scoreboard_pkg.sv
// Constants shared across the scoreboard: sequencer state codes, the 1 s cycle count
// used by the timer and the sequencer, and BCD digit values.
package scoreboard_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_PAUSE = 3'd2;
   localparam logic [2:0] ST_BUZZ  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;
   localparam logic [2:0] ST_FINAL = 3'd5;

   localparam int ONE_SEC = 25000000;

   localparam logic [3:0] ZERO  = 4'd0;
   localparam logic [3:0] ONE   = 4'd1;
   localparam logic [3:0] TWO   = 4'd2;
   localparam logic [3:0] THREE = 4'd3;
   localparam logic [3:0] FOUR  = 4'd4;
   localparam logic [3:0] FIVE  = 4'd5;
   localparam logic [3:0] SIX   = 4'd6;
   localparam logic [3:0] SEVEN = 4'd7;
   localparam logic [3:0] EIGHT = 4'd8;
   localparam logic [3:0] NINE  = 4'd9;

endpackage

// File: rtl/btn_edge_filter.sv
// Button front-end: optional counter debounce (GAME_CLK_DEBOUNCE_EN) then a registered
// one-cycle rise pulse; a held button yields a single pulse.
module btn_edge_filter
`ifdef GAME_CLK_DEBOUNCE_EN
   #(parameter int DEBOUNCE_CYC = 250000)
`endif
(
   input  logic clk_tm,
   input  logic rst_tm,
   input  logic btn,
   output logic rise
);

   logic lvl;
   logic btn_q;

`ifdef GAME_CLK_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   logic [CW-1:0] cnt;

   // lvl follows btn only after DEBOUNCE_CYC consecutive differing samples
   always_ff @(posedge clk_tm or posedge rst_tm) begin
      if (rst_tm) begin
         lvl <= 1'b0;
         cnt <= '0;
      end else if (btn == lvl) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
         lvl <= btn;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign lvl = btn;
`endif

   always_ff @(posedge clk_tm or posedge rst_tm) begin
      if (rst_tm) begin
         btn_q <= 1'b0;
         rise  <= 1'b0;
      end else begin
         btn_q <= lvl;
         rise  <= lvl & ~btn_q;
      end
   end

endmodule

// File: rtl/game_clock_ctrl.sv
// Game clock sequencer: buttons and timer zero flag -> run enable, reload pulse, period,
// buzzer and break countdown. GAME_CLK_DEBOUNCE_EN adds button debounce.
module game_clock_ctrl
   import scoreboard_pkg::*;
#(
`ifdef GAME_CLK_DEBOUNCE_EN
   parameter int DEBOUNCE_CYC = 250000,
`endif
   parameter int ONE_SEC     = scoreboard_pkg::ONE_SEC,
   parameter int NUM_PERIODS = 4,
   parameter int BUZZ_LEN    = 50000000,
   parameter int BREAK_SEC   = 120
)(
   input  logic       clk_tm,
   input  logic       rst_tm,
   input  logic       start_pause_btn,
   input  logic       clear_btn,
   input  logic       time_zero,
   output logic       tick_en,
   output logic       tm_clear,
   output logic [2:0] period,
   output logic       buzzer,
   output logic [7:0] break_sec,
   output logic [2:0] state_o
);

   localparam int PW = (ONE_SEC  > 1) ? $clog2(ONE_SEC)  : 1;
   localparam int BW = (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN) : 1;

   logic          start_rise;
   logic          clear_rise;
   logic [2:0]    state;
   logic [PW-1:0] presc;
   logic [BW-1:0] buzz_cnt;

`ifdef GAME_CLK_DEBOUNCE_EN
   btn_edge_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (
      .clk_tm(clk_tm), .rst_tm(rst_tm), .btn(start_pause_btn), .rise(start_rise));
   btn_edge_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
      .clk_tm(clk_tm), .rst_tm(rst_tm), .btn(clear_btn), .rise(clear_rise));
`else
   btn_edge_filter u_start (
      .clk_tm(clk_tm), .rst_tm(rst_tm), .btn(start_pause_btn), .rise(start_rise));
   btn_edge_filter u_clear (
      .clk_tm(clk_tm), .rst_tm(rst_tm), .btn(clear_btn), .rise(clear_rise));
`endif

   assign state_o = state;

   always_ff @(posedge clk_tm or posedge rst_tm) begin
      if (rst_tm) begin
         state     <= ST_IDLE;
         tick_en   <= 1'b0;
         tm_clear  <= 1'b0;
         period    <= 3'd1;
         buzzer    <= 1'b0;
         break_sec <= '0;
         presc     <= '0;
         buzz_cnt  <= '0;
      end else begin
         tm_clear <= 1'b0;
         if (clear_rise) begin
            // suppress the pulse if the timer was reloaded on the previous cycle
            tm_clear  <= ~tm_clear;
            state     <= ST_IDLE;
            tick_en   <= 1'b0;
            period    <= 3'd1;
            buzzer    <= 1'b0;
            break_sec <= '0;
            presc     <= '0;
            buzz_cnt  <= '0;
         end else begin
            case (state)
               ST_IDLE, ST_PAUSE: begin
                  if (start_rise) begin
                     state   <= ST_RUN;
                     tick_en <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (time_zero) begin
                     state    <= ST_BUZZ;
                     tick_en  <= 1'b0;
                     buzzer   <= 1'b1;
                     buzz_cnt <= '0;
                  end else if (start_rise) begin
                     state   <= ST_PAUSE;
                     tick_en <= 1'b0;
                  end
               end
               ST_BUZZ: begin
                  if (buzz_cnt == BW'(BUZZ_LEN - 1)) begin
                     buzzer   <= 1'b0;
                     buzz_cnt <= '0;
                     if (period == 3'(NUM_PERIODS)) begin
                        state <= ST_FINAL;
                     end else begin
                        period    <= period + 3'd1;
                        tm_clear  <= 1'b1;
                        break_sec <= 8'(BREAK_SEC);
                        presc     <= '0;
                        state     <= ST_BREAK;
                     end
                  end else begin
                     buzz_cnt <= buzz_cnt + 1'b1;
                  end
               end
               ST_BREAK: begin
                  if (start_rise) begin
                     break_sec <= '0;
                     presc     <= '0;
                     tick_en   <= 1'b1;
                     state     <= ST_RUN;
                  end else if (presc == PW'(ONE_SEC - 1)) begin
                     presc <= '0;
                     if (break_sec <= 8'd1) begin
                        break_sec <= '0;
                        state     <= ST_IDLE;
                     end else begin
                        break_sec <= break_sec - 8'd1;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               ST_FINAL: tick_en <= 1'b0;
               default: begin
                  state   <= ST_IDLE;
                  tick_en <= 1'b0;
                  buzzer  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Directed bench for game_clock_ctrl with short timing parameters.
module tb_game_clock_ctrl;

`ifdef GAME_CLK_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif
   // cycles from driving a button to the FSM reacting, and to settle after release
   localparam int LAT = 2 + DB;
   localparam int REL = 1 + DB;

   logic       clk_tm = 1'b0;
   logic       rst_tm = 1'b1;
   logic       start_pause_btn = 1'b0;
   logic       clear_btn = 1'b0;
   logic       time_zero = 1'b0;
   logic       tick_en, tm_clear, buzzer;
   logic [2:0] period, state_o;
   logic [7:0] break_sec;

   int checks = 0;
   int errors = 0;

   always #5 clk_tm = ~clk_tm;

   game_clock_ctrl #(
`ifdef GAME_CLK_DEBOUNCE_EN
      .DEBOUNCE_CYC(DB),
`endif
      .ONE_SEC(10),
      .NUM_PERIODS(2),
      .BUZZ_LEN(5),
      .BREAK_SEC(2)
   ) dut (
      .clk_tm(clk_tm),
      .rst_tm(rst_tm),
      .start_pause_btn(start_pause_btn),
      .clear_btn(clear_btn),
      .time_zero(time_zero),
      .tick_en(tick_en),
      .tm_clear(tm_clear),
      .period(period),
      .buzzer(buzzer),
      .break_sec(break_sec),
      .state_o(state_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_tm);
   endtask

   task automatic press(input bit is_clear);
      if (is_clear) clear_btn = 1'b1;
      else          start_pause_btn = 1'b1;
      cyc(LAT);
      clear_btn       = 1'b0;
      start_pause_btn = 1'b0;
      cyc(REL);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_tick"},   tick_en,   0);
      chk({tag, "_clr"},    tm_clear,  0);
      chk({tag, "_period"}, period,    1);
      chk({tag, "_buzz"},   buzzer,    0);
      chk({tag, "_brk"},    break_sec, 0);
      chk({tag, "_state"},  state_o,   0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(3);
      chk_rst("rst");
      rst_tm = 1'b0;
      cyc(2);

      // first start press: react exactly LAT cycles after driving
      start_pause_btn = 1'b1;
      cyc(LAT - 1);
      chk("idle_hold", state_o, 0);
      cyc(1);
      chk("run_state",  state_o, 1);
      chk("run_tick",   tick_en, 1);
      chk("run_period", period,  1);
      chk("run_buzz",   buzzer,  0);
      start_pause_btn = 1'b0;
      cyc(REL);

      press(0);
      chk("pause_state", state_o, 2);
      chk("pause_tick",  tick_en, 0);
      press(0);
      chk("resume_tick", tick_en, 1);

      start_pause_btn = 1'b1;
      cyc(50);
      start_pause_btn = 1'b0;
      cyc(REL);
      chk("held_state", state_o, 2);
      chk("held_tick",  tick_en, 0);
      press(0);
      chk("run_again", state_o, 1);

      // period 1 expires: buzz 5 cycles then break of 2 s
      time_zero = 1'b1;
      cyc(1);
      time_zero = 1'b0;
      chk("buzz_state", state_o, 3);
      chk("buzz_tick",  tick_en, 0);
      for (int i = 0; i < 5; i++) begin
         chk("buzz_on", buzzer, 1);
         cyc(1);
      end
      chk("buzz_off",  buzzer,    0);
      chk("brk_clr",   tm_clear,  1);
      chk("brk_per",   period,    2);
      chk("brk_sec2",  break_sec, 2);
      chk("brk_state", state_o,   4);
      cyc(1);
      chk("brk_clr_1cyc", tm_clear, 0);
      cyc(8);
      chk("brk_sec2_hold", break_sec, 2);
      cyc(1);
      chk("brk_sec1", break_sec, 1);
      cyc(9);
      chk("brk_sec1_hold", break_sec, 1);
      chk("brk_buzz", buzzer, 0);
      cyc(1);
      chk("brk_sec0",   break_sec, 0);
      chk("brk_idle",   state_o,   0);

      // period 2 expires: FINAL, no reload
      press(0);
      chk("p2_run", state_o, 1);
      time_zero = 1'b1;
      cyc(1);
      time_zero = 1'b0;
      cyc(5);
      chk("final_state", state_o,  5);
      chk("final_clr",   tm_clear, 0);
      chk("final_buzz",  buzzer,   0);
      chk("final_per",   period,   2);
      press(0);
      chk("final_hold", state_o, 5);
      chk("final_tick", tick_en, 0);

      clear_btn = 1'b1;
      cyc(LAT);
      chk("clr_pulse", tm_clear, 1);
      chk("clr_state", state_o,  0);
      chk("clr_per",   period,   1);
      cyc(1);
      chk("clr_pulse_end", tm_clear, 0);
      clear_btn = 1'b0;
      cyc(REL);

      // clear and start together in RUN
      press(0);
      chk("run3", state_o, 1);
      start_pause_btn = 1'b1;
      clear_btn       = 1'b1;
      cyc(LAT);
      chk("both_state", state_o,  0);
      chk("both_clr",   tm_clear, 1);
      chk("both_tick",  tick_en,  0);
      start_pause_btn = 1'b0;
      clear_btn       = 1'b0;
      cyc(REL);

      // time_zero and start rise in the same cycle
      press(0);
      start_pause_btn = 1'b1;
      cyc(LAT - 1);
      time_zero = 1'b1;
      cyc(1);
      chk("tz_prio_state", state_o, 3);
      chk("tz_prio_buzz",  buzzer,  1);
      time_zero       = 1'b0;
      start_pause_btn = 1'b0;

      // async reset in the middle of a break
      for (int i = 0; i < 60 && break_sec != 8'd1; i++) cyc(1);
      chk("pre_arst_brk", break_sec, 1);
      #2 rst_tm = 1'b1;
      #1 chk_rst("arst");
      cyc(2);
      rst_tm = 1'b0;
      cyc(2);

`ifdef GAME_CLK_DEBOUNCE_EN
      start_pause_btn = 1'b1;
      cyc(3);
      start_pause_btn = 1'b0;
      cyc(10);
      chk("db3_ignored", state_o, 0);
      start_pause_btn = 1'b1;
      cyc(4);
      start_pause_btn = 1'b0;
      cyc(10);
      chk("db4_accepted", state_o, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
